// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: FSM state encoding and default word-address width for the data-memory arbiter.
package dm_arb_pkg;
    localparam int N_DEF = 7;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: the two requester ports plus the single data-memory port seen by the arbiter.
interface dm_arbiter_if import dm_arb_pkg::*; #(parameter int N = N_DEF);
    logic          req0, req1, we0, we1;
    logic [N-1:0]  addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          ack0, ack1, busy;
    logic [31:0]   rdata;
    logic          mem_ena, mem_wea;
    logic [N-1:0]  mem_addra;
    logic [31:0]   mem_dina, mem_douta;
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_douta,
        output ack0, ack1, rdata, busy, mem_ena, mem_wea, mem_addra, mem_dina
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_douta,
        input  ack0, ack1, rdata, busy, mem_ena, mem_wea, mem_addra, mem_dina
    );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);
    always_comb grant_o = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: serialises two requesters onto one registered data-memory port,
// one access per three cycles (IDLE -> ISSUE -> RESP).
module dm_arbiter import dm_arb_pkg::*; #(parameter int N = N_DEF) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave bus
);
    state_e        state_q;
    logic          last_q, own_q, we_q, ena_q, ack0_q, ack1_q, gnt;
    logic [N-1:0]  addr_q;
    logic [31:0]   wdata_q;
    rr_arb2 u_rr (.req_i({bus.req1, bus.req0}), .last_i(last_q), .grant_o(gnt));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ena_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req0 | bus.req1) begin
                    state_q <= ISSUE;
                    own_q   <= gnt;
                    last_q  <= gnt;
                    we_q    <= gnt ? bus.we1 : bus.we0;
                    addr_q  <= gnt ? bus.addr1 : bus.addr0;
                    wdata_q <= gnt ? bus.wdata1 : bus.wdata0;
                    ena_q   <= 1'b1;
                end
                ISSUE: begin
                    state_q <= RESP;
                    ena_q   <= 1'b0;
                    ack0_q  <= ~own_q;
                    ack1_q  <= own_q;
                end
                default: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
            endcase
        end
    end
    // memory drive is gated by the ISSUE pulse so the port reads as all-zero otherwise
    assign bus.busy      = state_q != IDLE;
    assign bus.mem_ena   = ena_q;
    assign bus.mem_wea   = ena_q & we_q;
    assign bus.mem_addra = ena_q ? addr_q : '0;
    assign bus.mem_dina  = ena_q ? wdata_q : '0;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = !(ack0_q | ack1_q) ? '0 : we_q ? wdata_q : bus.mem_douta;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus random traffic scored against a transaction-level model.
module tb_dm_arbiter;
    import dm_arb_pkg::*;
    localparam int N = N_DEF;
    localparam int DEPTH = 1 << N;
    typedef struct { int cyc; bit port; logic [31:0] data; } resp_t;
    typedef struct { int cyc; bit we; logic [N-1:0] addr; logic [31:0] din; } iss_t;

    logic clk = 0;
    logic rst = 1;
    dm_arbiter_if #(.N(N)) bus();
    dm_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    logic [31:0] refm [DEPTH];
    always @(posedge clk)
        if (bus.mem_ena) begin
            if (bus.mem_wea) mem[bus.mem_addra] <= bus.mem_dina;
            bus.mem_douta <= mem[bus.mem_addra];
        end

    int checks = 0, errors = 0;
    int cyc = 0, free_at = 0, busy_until = -1, act_due = 0;
    bit last_m = 1, own_m = 0;
    resp_t rq[$];
    iss_t iq[$];
    bit ack_log[$];
    int ack_cyc[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: the memory is free every third cycle; an access granted at edge c
    // shows on the memory port after c and is acked after c+1.
    bit mp, mw;
    logic [N-1:0] ma;
    logic [31:0] md;
    always @(posedge clk) begin
        if (rst) begin
            rq.delete();
            iq.delete();
            free_at = cyc + 1;
            busy_until = -1;
            act_due = 0;
            last_m = 1;
        end else if (cyc >= free_at && (bus.req0 || bus.req1)) begin
            mp = (bus.req0 && bus.req1) ? !last_m : bus.req1;
            mw = mp ? bus.we1 : bus.we0;
            ma = mp ? bus.addr1 : bus.addr0;
            md = mp ? bus.wdata1 : bus.wdata0;
            iq.push_back('{cyc + 1, mw, ma, md});
            rq.push_back('{cyc + 2, mp, mw ? md : refm[ma]});
            if (mw) refm[ma] = md;
            last_m = mp;
            own_m = mp;
            free_at = cyc + 3;
            busy_until = cyc + 2;
            act_due = cyc + 2;
        end
        cyc++;
    end

    iss_t ie;
    resp_t re;
    always @(negedge clk) begin
        if (iq.size() > 0 && iq[0].cyc == cyc) begin
            ie = iq.pop_front();
            check("mem_ena", 32'(bus.mem_ena), 32'd1);
            check("mem_wea", 32'(bus.mem_wea), 32'(ie.we));
            check("mem_addra", 32'(bus.mem_addra), 32'(ie.addr));
            check("mem_dina", bus.mem_dina, ie.din);
        end else begin
            check("mem_idle_ctl", 32'({bus.mem_ena, bus.mem_wea, bus.mem_addra}), 32'd0);
            check("mem_idle_din", bus.mem_dina, 32'd0);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            re = rq.pop_front();
            check("ack0", 32'(bus.ack0), 32'(!re.port));
            check("ack1", 32'(bus.ack1), 32'(re.port));
            check("rdata", bus.rdata, re.data);
        end else begin
            check("ack_idle", 32'({bus.ack0, bus.ack1}), 32'd0);
        end
        check("busy", 32'(bus.busy), 32'(cyc <= busy_until));
        if (bus.ack0) begin ack_log.push_back(1'b0); ack_cyc.push_back(cyc); end
        if (bus.ack1) begin ack_log.push_back(1'b1); ack_cyc.push_back(cyc); end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input bit w, input logic [N-1:0] a, input logic [31:0] d);
        if (p) begin bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        else begin bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    endtask

    task automatic access(input bit p, input bit w, input logic [N-1:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int n);
        bit got;
        got = 0;
        n = 0;
        rd = '0;
        set_port(p, w, a, d);
        if (p) bus.req1 = 1; else bus.req0 = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            n++;
            if (p ? bus.ack1 : bus.ack0) begin got = 1; rd = bus.rdata; end
        end
        check("ack_timeout", 32'(got), 32'd1);
        bus.req0 = 0;
        bus.req1 = 0;
        tick();
    endtask

    task automatic drive(input bit p);
        logic r, a;
        r = p ? bus.req1 : bus.req0;
        a = p ? bus.ack1 : bus.ack0;
        if (r && (a || (cyc < act_due && own_m == p && $urandom_range(7) == 0))) r = 0;
        else if (!r && $urandom_range(2) == 0) begin
            set_port(p, 1'($urandom), N'($urandom), $urandom);
            r = 1;
        end
        if (p) bus.req1 = r; else bus.req0 = r;
    endtask

    logic [31:0] rd;
    int n;
    initial begin
        {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
        {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; refm[i] = mem[i]; end
        mem[5] = 32'hDEAD_BEEF;
        refm[5] = 32'hDEAD_BEEF;
        repeat (2) tick();
        rst = 0;
        // single read: ack two cycles after the request
        access(0, 0, 5, 0, rd, n);
        check("read5_data", rd, 32'hDEAD_BEEF);
        check("read5_latency", 32'(n), 32'd2);
        // write through port 1, read back through port 0
        access(1, 1, 9, 32'h1234_5678, rd, n);
        check("write9_ack", rd, 32'h1234_5678);
        access(0, 0, 9, 0, rd, n);
        check("read9_data", rd, 32'h1234_5678);
        // tie right after reset: 0,1,0,1
        rst = 1;
        tick();
        rst = 0;
        ack_log.delete();
        set_port(0, 0, 3, 0);
        set_port(1, 0, 4, 0);
        bus.req0 = 1;
        bus.req1 = 1;
        repeat (11) tick();
        bus.req0 = 0;
        bus.req1 = 0;
        repeat (3) tick();
        check("tie_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4)
            for (int i = 0; i < 4; i++) check("tie_order", 32'(ack_log[i]), 32'(i % 2));
        // reset during ISSUE aborts the ack but keeps the issued write
        ack_log.delete();
        set_port(0, 1, 20, 32'hA5A5_5A5A);
        bus.req0 = 1;
        tick();
        check("abort_issue", 32'(bus.mem_ena), 32'd1);
        rst = 1;
        bus.req0 = 0;
        tick();
        rst = 0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check("abort_no_ack", 32'(ack_log.size()), 32'd0);
        access(0, 0, 20, 0, rd, n);
        check("abort_write_kept", rd, 32'hA5A5_5A5A);
        // request dropped in ISSUE still completes, exactly once
        ack_log.delete();
        set_port(1, 0, 33, 0);
        bus.req1 = 1;
        tick();
        bus.req1 = 0;
        repeat (5) tick();
        check("drop_count", 32'(ack_log.size()), 32'd1);
        if (ack_log.size() == 1) check("drop_port", 32'(ack_log[0]), 32'd1);
        // non-owner arriving during ISSUE is served three cycles after the owner
        ack_log.delete();
        ack_cyc.delete();
        set_port(0, 0, 40, 0);
        bus.req0 = 1;
        tick();
        set_port(1, 0, 41, 0);
        bus.req1 = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.ack0) bus.req0 = 0;
            if (bus.ack1) bus.req1 = 0;
        end
        check("wait_count", 32'(ack_cyc.size()), 32'd2);
        if (ack_cyc.size() == 2) begin
            check("wait_order", 32'({ack_log[0], ack_log[1]}), 32'b01);
            check("wait_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        end
        // random traffic with occasional resets
        bus.req0 = 0;
        bus.req1 = 0;
        repeat (800) begin
            rst = $urandom_range(149) == 0;
            if (rst) begin
                bus.req0 = 0;
                bus.req1 = 0;
            end else begin
                drive(0);
                drive(1);
            end
            tick();
        end
        rst = 0;
        bus.req0 = 0;
        bus.req1 = 0;
        repeat (6) tick();
        check("drain", 32'(rq.size() + iq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
